// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand channel (in_*, a, b, bin)
// and result channel (out_*, diff, bout). The optional ovf signal exists
// only when SERSUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell and a registered borrow.
// Operands arrive on a valid/ready handshake, the result leaves on another.
// Optional macro SERSUB_SIGNED_OVF_EN adds the two's-complement overflow
// output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             br_reg;
  logic             bout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [CW-1:0]    cnt_reg;

  logic             d_bit;
  logic             br_next;

`ifdef SERSUB_SIGNED_OVF_EN
  // Overflow is the borrow into the MSB stage xor the borrow out of it;
  // latched during the last bit cycle and published on entry to DONE.
  logic ovf_pend_reg;
  logic ovf_reg;
  assign bus.ovf = ovf_reg;
`endif

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;

  // Full-subtractor cell on the operand LSBs and the running borrow.
  always_comb begin
    d_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    br_next = (~a_sh_reg[0] & b_sh_reg[0]) |
              (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
  end

  // Control FSM plus datapath; all outputs are registered. The counter stops
  // at WIDTH, and the SHIFT state spends one extra cycle at the saturated
  // count to move the result into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_reg       <= '0;
      diff_reg      <= '0;
      br_reg        <= 1'b0;
      bout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_pend_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_sh_reg     <= bus.a;
            b_sh_reg     <= bus.b;
            br_reg       <= bus.bin;
            res_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_reg == CNT_MAX) begin
            diff_reg      <= res_reg;
            bout_reg      <= br_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_reg       <= ovf_pend_reg;
`endif
          end else begin
            res_reg  <= {d_bit, res_reg[WIDTH-1:1]};
            a_sh_reg <= a_sh_reg >> 1;
            b_sh_reg <= b_sh_reg >> 1;
            br_reg   <= br_next;
            cnt_reg  <= cnt_reg + 1'b1;
`ifdef SERSUB_SIGNED_OVF_EN
            if (cnt_reg == CNT_LAST) begin
              ovf_pend_reg <= br_reg ^ br_next;
            end
`endif
          end
        end
        DONE: begin
          // Result held until consumed; no reload in the same cycle.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifndef SERSUB_SIGNED_OVF_EN
  // Keeps the last-bit index referenced in the default build.
  logic unused_cnt_last;
  assign unused_cnt_last = ^CNT_LAST;
`endif

endmodule
